pc_fetch_unit: RTL and testbench

//   Program-counter stage directly upstream of the instruction memory. Holds the
//   PC as a word index and drives the memory's instr_add_PC address input.

---
 rtl/pc_fetch_unit.sv | 132 +++++++++++++
 tb/tb_pc_fetch_unit.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_unit.sv
// Program-counter stage feeding the instruction memory: next-PC selection for
// sequential / beq / j flow, stall, halt-on-self-jump, range fault and retire counter.
module pc_fetch_unit #(
  parameter int ADDR_W     = 32,
  parameter int IMEM_DEPTH = 32,
  parameter int RESET_PC   = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic [31:0]       instr_in,
  input  logic              alu_zero,
  output logic [ADDR_W-1:0] pc_out,
  output logic [ADDR_W-1:0] pc_plus1,
  output logic              branch_taken,
  output logic              jump_taken,
  output logic              halted,
  output logic              fault,
  output logic [31:0]       instr_count
);

  // state  | meaning
  // S_BOOT | first cycle after reset; PC held while memory presents word 0
  // S_RUN  | normal fetch, one instruction retired per unstalled edge
  // S_HALT | terminal (self-jump or fault); everything frozen until rst
  localparam logic [1:0] S_BOOT = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_HALT = 2'd2;

  localparam logic [5:0]        OP_J       = 6'b000010;
  localparam logic [5:0]        OP_BEQ     = 6'b000100;
  localparam logic [ADDR_W-1:0] L_RESET_PC = ADDR_W'(RESET_PC);
  localparam logic [ADDR_W-1:0] L_DEPTH    = ADDR_W'(IMEM_DEPTH);
  localparam logic [ADDR_W-1:0] L_ONE      = ADDR_W'(1);
  localparam logic [31:0]       CNT_MAX    = 32'hFFFF_FFFF;

  logic [1:0]        r_state;
  logic [ADDR_W-1:0] r_pc;
  logic              r_fault;
  logic [31:0]       r_count;

  logic [5:0]        w_op;
  logic              w_is_j;
  logic              w_is_beq;
  logic              w_in_run;
  logic              w_take_beq;
  logic [ADDR_W-1:0] w_pc_plus1;
  logic [ADDR_W-1:0] w_j_target;
  logic [ADDR_W-1:0] w_br_offset;
  logic [ADDR_W-1:0] w_br_target;
  logic [ADDR_W-1:0] w_next_pc;
  logic              w_out_of_range;
  logic              w_self_jump;

  logic [1:0]        w_state_d;
  logic [ADDR_W-1:0] w_pc_d;
  logic              w_fault_d;
  logic              w_retire;

  assign w_op       = instr_in[31:26];
  assign w_is_j     = (w_op == OP_J);
  assign w_is_beq   = (w_op == OP_BEQ);
  assign w_in_run   = (r_state == S_RUN);
  assign w_take_beq = w_is_beq & alu_zero;

  assign w_pc_plus1  = r_pc + L_ONE;
  assign w_j_target  = {{(ADDR_W-26){1'b0}}, instr_in[25:0]};
  assign w_br_offset = {{(ADDR_W-16){instr_in[15]}}, instr_in[15:0]};
  assign w_br_target = w_pc_plus1 + w_br_offset;

  // j wins over beq; both addresses wrap modulo 2^ADDR_W before the range check
  always_comb begin
    w_next_pc = w_pc_plus1;
    if (w_is_j)
      w_next_pc = w_j_target;
    else if (w_take_beq)
      w_next_pc = w_br_target;
  end

  assign w_out_of_range = (w_next_pc >= L_DEPTH);
  assign w_self_jump    = w_is_j & (w_j_target == r_pc);

  always_comb begin
    w_state_d = r_state;
    w_pc_d    = r_pc;
    w_fault_d = r_fault;
    w_retire  = 1'b0;
    case (r_state)
      S_BOOT: w_state_d = S_RUN;
      S_RUN: begin
        if (!stall) begin
          // an illegal target faults even if it would also be a self-jump
          if (w_out_of_range) begin
            w_fault_d = 1'b1;
            w_state_d = S_HALT;
          end else if (w_self_jump) begin
            w_retire  = 1'b1;
            w_state_d = S_HALT;
          end else begin
            w_pc_d   = w_next_pc;
            w_retire = 1'b1;
          end
        end
      end
      default: w_state_d = r_state;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_BOOT;
      r_pc    <= L_RESET_PC;
      r_fault <= 1'b0;
      r_count <= '0;
    end else begin
      r_state <= w_state_d;
      r_pc    <= w_pc_d;
      r_fault <= w_fault_d;
      if (w_retire && (r_count != CNT_MAX))
        r_count <= r_count + 32'd1;
    end
  end

  assign pc_out       = r_pc;
  assign pc_plus1     = w_pc_plus1;
  assign branch_taken = w_in_run & w_take_beq;
  assign jump_taken   = w_in_run & w_is_j;
  assign halted       = (r_state == S_HALT);
  assign fault        = r_fault;
  assign instr_count  = r_count;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit: reset/boot, jump, branch, stall, fault, self-jump halt.
module tb_pc_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic [31:0] instr_in;
  logic        alu_zero;
  logic [31:0] pc_out;
  logic [31:0] pc_plus1;
  logic        branch_taken;
  logic        jump_taken;
  logic        halted;
  logic        fault;
  logic [31:0] instr_count;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_count;

  localparam logic [31:0] NOP = 32'h0000_0000;

  always #5 clk = ~clk;

  pc_fetch_unit #(.ADDR_W(32), .IMEM_DEPTH(32), .RESET_PC(0)) dut (
    .clk(clk), .rst(rst), .stall(stall), .instr_in(instr_in), .alu_zero(alu_zero),
    .pc_out(pc_out), .pc_plus1(pc_plus1), .branch_taken(branch_taken),
    .jump_taken(jump_taken), .halted(halted), .fault(fault), .instr_count(instr_count)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] j_instr(input int target);
    return 32'h0800_0000 | (32'(target) & 32'h03FF_FFFF);
  endfunction

  // reach a given PC from RUN with a j; retires one instruction
  task automatic goto_pc(input int target);
    stall = 1'b0; alu_zero = 1'b0; instr_in = j_instr(target);
    tick();
    exp_count = exp_count + 32'd1;
  endtask

  // reset for one cycle, then leave BOOT so the unit sits in RUN at pc 0
  task automatic do_reset();
    rst = 1'b1; stall = 1'b0; alu_zero = 1'b0; instr_in = NOP;
    tick();
    rst = 1'b0;
    tick();
    exp_count = 32'd0;
  endtask

  task automatic test_reset();
    rst = 1'b1; stall = 1'b0; alu_zero = 1'b0; instr_in = NOP;
    tick(); tick();
    checks++; if (pc_out !== 32'd0) begin errors++; $display("FAIL reset_pc: got %0d expected 0", pc_out); end
    checks++; if (halted !== 1'b0 || fault !== 1'b0) begin errors++; $display("FAIL reset_flags: got halted=%0b fault=%0b expected 0/0", halted, fault); end
    checks++; if (instr_count !== 32'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", instr_count); end
    instr_in = j_instr(7);
    #1;
    checks++; if (jump_taken !== 1'b0) begin errors++; $display("FAIL boot_jump_masked: got %0b expected 0", jump_taken); end
    // BOOT ignores stall and holds PC
    rst = 1'b0; stall = 1'b1; instr_in = NOP;
    tick();
    checks++; if (pc_out !== 32'd0 || instr_count !== 32'd0) begin errors++; $display("FAIL boot_hold: got pc=%0d cnt=%0d expected 0/0", pc_out, instr_count); end
    stall = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      tick();
      checks++; if (pc_out !== 32'(i) || instr_count !== 32'(i)) begin errors++; $display("FAIL seq_%0d: got pc=%0d cnt=%0d expected %0d/%0d", i, pc_out, instr_count, i, i); end
    end
    checks++; if (pc_plus1 !== 32'd4) begin errors++; $display("FAIL pc_plus1: got %0d expected 4", pc_plus1); end
    exp_count = 32'd3;
  endtask

  task automatic test_jump();
    goto_pc(8);
    checks++; if (pc_out !== 32'd8) begin errors++; $display("FAIL jump_to_8: got %0d expected 8", pc_out); end
    instr_in = 32'h0800_0001;
    #1;
    checks++; if (jump_taken !== 1'b1 || branch_taken !== 1'b0) begin errors++; $display("FAIL jump_decode: got j=%0b b=%0b expected 1/0", jump_taken, branch_taken); end
    tick();
    exp_count = exp_count + 32'd1;
    checks++; if (pc_out !== 32'd1 || instr_count !== exp_count) begin errors++; $display("FAIL jump_exec: got pc=%0d cnt=%0d expected 1/%0d", pc_out, instr_count, exp_count); end
  endtask

  task automatic test_branch();
    goto_pc(9);
    instr_in = 32'h1042_0002; alu_zero = 1'b1;
    #1;
    checks++; if (branch_taken !== 1'b1) begin errors++; $display("FAIL beq_taken_flag: got %0b expected 1", branch_taken); end
    tick();
    exp_count = exp_count + 32'd1;
    checks++; if (pc_out !== 32'd12 || instr_count !== exp_count) begin errors++; $display("FAIL beq_taken_pc: got pc=%0d cnt=%0d expected 12/%0d", pc_out, instr_count, exp_count); end
    goto_pc(9);
    instr_in = 32'h1042_0002; alu_zero = 1'b0;
    #1;
    checks++; if (branch_taken !== 1'b0) begin errors++; $display("FAIL beq_not_taken_flag: got %0b expected 0", branch_taken); end
    tick();
    exp_count = exp_count + 32'd1;
    checks++; if (pc_out !== 32'd10) begin errors++; $display("FAIL beq_not_taken_pc: got %0d expected 10", pc_out); end
  endtask

  task automatic test_back_branch_stall();
    goto_pc(5);
    instr_in = 32'h1000_FFFE; alu_zero = 1'b1;
    tick();
    exp_count = exp_count + 32'd1;
    checks++; if (pc_out !== 32'd4) begin errors++; $display("FAIL beq_back: got %0d expected 4", pc_out); end
    stall = 1'b1; alu_zero = 1'b0; instr_in = j_instr(20);
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (jump_taken !== 1'b1) begin errors++; $display("FAIL stall_decode_%0d: got %0b expected 1", i, jump_taken); end
      tick();
      checks++; if (pc_out !== 32'd4 || instr_count !== exp_count) begin errors++; $display("FAIL stall_hold_%0d: got pc=%0d cnt=%0d expected 4/%0d", i, pc_out, instr_count, exp_count); end
    end
    stall = 1'b0; instr_in = NOP;
    tick();
    exp_count = exp_count + 32'd1;
    checks++; if (pc_out !== 32'd5 || instr_count !== exp_count) begin errors++; $display("FAIL stall_release: got pc=%0d cnt=%0d expected 5/%0d", pc_out, instr_count, exp_count); end
  endtask

  task automatic test_fault();
    goto_pc(31);
    instr_in = NOP;
    tick();
    checks++; if (pc_out !== 32'd31 || fault !== 1'b1 || halted !== 1'b1) begin errors++; $display("FAIL fault_edge: got pc=%0d fault=%0b halted=%0b expected 31/1/1", pc_out, fault, halted); end
    checks++; if (instr_count !== exp_count) begin errors++; $display("FAIL fault_count: got %0d expected %0d", instr_count, exp_count); end
    instr_in = j_instr(5);
    #1;
    checks++; if (jump_taken !== 1'b0) begin errors++; $display("FAIL halt_jump_masked: got %0b expected 0", jump_taken); end
    instr_in = 32'h1000_0001; alu_zero = 1'b1;
    #1;
    checks++; if (branch_taken !== 1'b0) begin errors++; $display("FAIL halt_branch_masked: got %0b expected 0", branch_taken); end
    tick(); tick();
    checks++; if (pc_out !== 32'd31 || instr_count !== exp_count || fault !== 1'b1 || halted !== 1'b1) begin errors++; $display("FAIL halt_frozen: got pc=%0d cnt=%0d fault=%0b halted=%0b expected 31/%0d/1/1", pc_out, instr_count, fault, halted, exp_count); end
  endtask

  task automatic test_self_jump();
    do_reset();
    checks++; if (fault !== 1'b0 || halted !== 1'b0 || pc_out !== 32'd0) begin errors++; $display("FAIL reset_clears_fault: got fault=%0b halted=%0b pc=%0d expected 0/0/0", fault, halted, pc_out); end
    goto_pc(3);
    instr_in = 32'h0800_0003;
    tick();
    exp_count = exp_count + 32'd1;
    checks++; if (halted !== 1'b1 || pc_out !== 32'd3 || instr_count !== exp_count || fault !== 1'b0) begin errors++; $display("FAIL self_jump: got halted=%0b pc=%0d cnt=%0d fault=%0b expected 1/3/%0d/0", halted, pc_out, instr_count, fault, exp_count); end
    rst = 1'b1;
    tick();
    checks++; if (pc_out !== 32'd0 || halted !== 1'b0 || fault !== 1'b0 || instr_count !== 32'd0) begin errors++; $display("FAIL halt_reset: got pc=%0d halted=%0b fault=%0b cnt=%0d expected 0/0/0/0", pc_out, halted, fault, instr_count); end
    rst = 1'b0; instr_in = NOP;
    tick();
    exp_count = 32'd0;
  endtask

  task automatic test_wrap_fault();
    // pc 0 + 1 - 2 wraps to all-ones, which is out of range
    instr_in = 32'h1000_FFFE; alu_zero = 1'b1; stall = 1'b0;
    tick();
    checks++; if (fault !== 1'b1 || halted !== 1'b1 || pc_out !== 32'd0 || instr_count !== 32'd0) begin errors++; $display("FAIL wrap_fault: got fault=%0b halted=%0b pc=%0d cnt=%0d expected 1/1/0/0", fault, halted, pc_out, instr_count); end
    alu_zero = 1'b0;
  endtask

  task automatic test_reset_during_stall();
    do_reset();
    goto_pc(6);
    stall = 1'b1; rst = 1'b1; instr_in = NOP;
    tick();
    checks++; if (pc_out !== 32'd0 || instr_count !== 32'd0 || halted !== 1'b0) begin errors++; $display("FAIL stall_reset: got pc=%0d cnt=%0d halted=%0b expected 0/0/0", pc_out, instr_count, halted); end
    rst = 1'b0;
    tick();
    tick();
    checks++; if (pc_out !== 32'd0) begin errors++; $display("FAIL stall_after_boot: got %0d expected 0", pc_out); end
    stall = 1'b0;
    tick();
    checks++; if (pc_out !== 32'd1 || instr_count !== 32'd1) begin errors++; $display("FAIL resume_after_stall: got pc=%0d cnt=%0d expected 1/1", pc_out, instr_count); end
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; instr_in = NOP; alu_zero = 1'b0; exp_count = 32'd0;
    test_reset();
    test_jump();
    test_branch();
    test_back_branch_stall();
    test_fault();
    test_self_jump();
    test_wrap_fault();
    test_reset_during_stall();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
